// File: rtl/rv32i_fetch_pkg.sv
// Shared constants for the RV32I fetch stage: canonical NOP, default
// geometry and a constant-evaluable ceil(log2) helper.
package rv32i_fetch_pkg;

  localparam logic [31:0] RV_NOP    = 32'h00000013;
  localparam int unsigned DEF_WIDTH = 32'd32;
  localparam int unsigned DEF_DEPTH = 32'd4;

  // Smallest n with 2**n >= value; used to size ring pointers.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    while ((32'd1 << result) < value) begin
      result = result + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ifb_ring.sv
// Ring storage for the fetch buffer: {pc, instr, filled} per entry with
// independent alloc (issue), fill (response) and rd (decode pop) pointers.
// A flush drops every entry and rewinds all pointers to slot 0.
module ifb_ring
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned PW   = clog2(DEPTH),
  localparam int unsigned CW   = PW + 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic [WIDTH-1:0] alloc_pc,
  input  logic             fill,
  input  logic [31:0]      fill_instr,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_pc,
  output logic [31:0]      head_instr,
  output logic             head_filled,
  output logic [CW-1:0]    filled_count
);

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    alloc_ptr;
  logic [PW-1:0]    fill_ptr;
  logic [PW-1:0]    rd_ptr;

  // Payload capture; validity lives in the filled bits, so no reset needed here.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem[alloc_ptr] <= alloc_pc;
    end
    if (fill) begin
      instr_mem[fill_ptr] <= fill_instr;
    end
  end

  // Pointer advance and filled-bit bookkeeping; reset and flush rewind everything.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      filled    <= '0;
    end else begin
      if (alloc) begin
        alloc_ptr         <= alloc_ptr + 1'b1;
        filled[alloc_ptr] <= 1'b0;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + 1'b1;
        filled[rd_ptr] <= 1'b0;
      end
      if (fill) begin
        fill_ptr         <= fill_ptr + 1'b1;
        filled[fill_ptr] <= 1'b1;
      end
    end
  end

  // Population count of filled entries, used to tell owed responses from unsolicited ones.
  always_comb begin
    filled_count = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      filled_count = filled_count + CW'(filled[i]);
    end
  end

  assign head_pc     = pc_mem[rd_ptr];
  assign head_instr  = instr_mem[rd_ptr];
  assign head_filled = filled[rd_ptr];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage between the PC and decode. Issues in-order instruction reads,
// buffers up to DEPTH entries, and discards responses that belong to
// requests flushed by a redirect.
module instr_fetch_buffer
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_addr,
  input  logic             redirect,
  output logic             pc_hold,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [WIDTH-1:0] id_pc
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 32'd1;
  localparam int unsigned SW = CW + 32'd1;
  localparam logic [SW-1:0] DEPTH_SUM = SW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = {{PW{1'b0}}, 1'b1};

  logic [CW-1:0]    count;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    discard_next;
  logic [CW-1:0]    filled_count;
  logic [CW-1:0]    unfilled;
  logic [CW-1:0]    owed;
  logic [SW-1:0]    sum;
  logic             issue;
  logic             pop;
  logic             fill;
  logic [WIDTH-1:0] head_pc;
  logic [31:0]      head_instr;
  logic             head_filled;

  ifb_ring #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk          (clk),
    .rst          (rst),
    .alloc        (issue),
    .alloc_pc     (pc_addr),
    .fill         (fill),
    .fill_instr   (imem_rdata),
    .pop          (pop),
    .flush        (redirect),
    .head_pc      (head_pc),
    .head_instr   (head_instr),
    .head_filled  (head_filled),
    .filled_count (filled_count)
  );

  // Issue/fill/pop strobes from registered occupancy; a pop frees no credit this cycle.
  always_comb begin
    issue    = 1'b0;
    pop      = 1'b0;
    fill     = 1'b0;
    unfilled = count - filled_count;
    sum      = {1'b0, count} + {1'b0, discard};
    if (rst && !redirect) begin
      issue = (sum < DEPTH_SUM);
      pop   = head_filled && (count != '0) && id_ready;
      fill  = imem_rvalid && (discard == '0) && (count > filled_count);
    end else begin
      issue = 1'b0;
      pop   = 1'b0;
      fill  = 1'b0;
    end
  end

  // Occupancy and owed-response bookkeeping; a redirect converts in-flight entries into discards.
  always_comb begin
    count_next   = count;
    discard_next = discard;
    owed         = discard + unfilled;
    if (redirect) begin
      count_next = '0;
      if (imem_rvalid && (owed != '0)) begin
        discard_next = owed - CNT_ONE;
      end else begin
        discard_next = owed;
      end
    end else begin
      count_next = count + CW'(issue) - CW'(pop);
      if (imem_rvalid && (discard != '0)) begin
        discard_next = discard - CNT_ONE;
      end else begin
        discard_next = discard;
      end
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      discard <= '0;
    end else begin
      count   <= count_next;
      discard <= discard_next;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_addr;
  assign pc_hold   = !rst || (!issue && !redirect);
  assign id_valid  = rst && head_filled && (count != '0);
  assign id_instr  = id_valid ? head_instr : RV_NOP;
  assign id_pc     = id_valid ? head_pc : '0;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: a fixed-latency in-order memory
// model, a PC model and a scoreboard of expected {pc, instr} pairs.
module tb_instr_fetch_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        redirect;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  instr_fetch_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .redirect    (redirect),
    .pc_hold     (pc_hold),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  logic [31:0] pc;
  logic [31:0] target;
  int          lat;
  int          cyc;
  logic        inject;
  logic [31:0] inject_data;

  logic [31:0] exp_pc [$];
  logic [31:0] mem_q  [$];
  int          mem_due[$];

  logic        s_req, s_hold, s_valid;
  logic [31:0] s_pc, s_instr;
  int          n_req, n_pop;
  logic [31:0] last_pop_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A0003;
  endfunction

  // One clock cycle: drive memory, sample outputs mid-cycle, score, advance models.
  task automatic cycle();
    logic [31:0] e;
    pc_addr = pc;
    if (inject) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inject_data;
    end else if (mem_q.size() > 0 && mem_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    s_req = imem_req; s_hold = pc_hold; s_valid = id_valid;
    s_pc = id_pc; s_instr = id_instr;
    if (s_req) begin
      checks++;
      if (imem_addr !== pc_addr) begin
        failures++;
        $display("FAIL imem_addr: got %h expected %h", imem_addr, pc_addr);
      end
      exp_pc.push_back(pc_addr);
      mem_q.push_back(pc_addr);
      mem_due.push_back(cyc + lat);
      n_req++;
    end
    if (s_valid && id_ready && !redirect && rst) begin
      checks++;
      if (exp_pc.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got pc %h expected no output", s_pc);
      end else begin
        e = exp_pc.pop_front();
        if (s_pc !== e || s_instr !== instr_of(e)) begin
          failures++;
          $display("FAIL sb_pair: got %h/%h expected %h/%h", s_pc, s_instr, e, instr_of(e));
        end
      end
      n_pop++;
      last_pop_pc = s_pc;
    end
    @(posedge clk);
    if (imem_rvalid && !inject) begin
      void'(mem_q.pop_front());
      void'(mem_due.pop_front());
    end
    if (!rst) begin
      exp_pc.delete(); mem_q.delete(); mem_due.delete();
    end else if (redirect) begin
      exp_pc.delete();
    end
    if (redirect) pc = target;
    else if (!s_hold) pc = pc + 32'd4;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst = 1'b0; redirect = 1'b0; inject = 1'b0;
    cycle();
    rst = 1'b1;
    pc = start;
  endtask

  task automatic test_reset();
    rst = 1'b0; id_ready = 1'b1; redirect = 1'b0;
    cycle();
    checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", s_req); end
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
    checks++; if (s_instr !== NOP) begin failures++; $display("FAIL reset_instr: got %h expected %h", s_instr, NOP); end
    redirect = 1'b1; target = 32'h0;
    cycle();
    redirect = 1'b0;
    checks++; if (s_hold !== 1'b1) begin failures++; $display("FAIL reset_hold: got %b expected 1", s_hold); end
    rst = 1'b1; pc = 32'h0;
  endtask

  task automatic test_stream();
    int r0, p0;
    do_reset(32'h0); lat = 1; id_ready = 1'b1;
    r0 = n_req; p0 = n_pop;
    cycle();
    checks++; if (s_req !== 1'b1) begin failures++; $display("FAIL stream_first_req: got %b expected 1", s_req); end
    checks++; if (s_hold !== 1'b0) begin failures++; $display("FAIL stream_hold: got %b expected 0", s_hold); end
    for (int i = 0; i < 5; i++) cycle();
    checks++; if (n_req - r0 != 6) begin failures++; $display("FAIL stream_reqs: got %0d expected 6", n_req - r0); end
    checks++; if (n_pop - p0 != 4) begin failures++; $display("FAIL stream_pops: got %0d expected 4", n_pop - p0); end
  endtask

  task automatic test_backpressure();
    int r0;
    do_reset(32'h0); lat = 1; id_ready = 1'b0;
    r0 = n_req;
    for (int i = 0; i < 6; i++) cycle();
    checks++; if (n_req - r0 != 4) begin failures++; $display("FAIL bp_reqs: got %0d expected 4", n_req - r0); end
    checks++; if (s_req !== 1'b0 || s_hold !== 1'b1) begin failures++; $display("FAIL bp_full: got req=%b hold=%b expected req=0 hold=1", s_req, s_hold); end
    id_ready = 1'b1;
    cycle();
    id_ready = 1'b0;
    checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL bp_pop_same_cycle: got %b expected 0", s_req); end
    checks++; if (last_pop_pc !== 32'h0) begin failures++; $display("FAIL bp_pop_pc: got %h expected 0", last_pop_pc); end
    cycle();
    checks++; if (s_req !== 1'b1 || pc_addr !== 32'h10) begin failures++; $display("FAIL bp_reissue: got req=%b addr=%h expected 1/10", s_req, pc_addr); end
  endtask

  task automatic test_redirect_discard();
    int p0, bad;
    logic got;
    do_reset(32'h0); lat = 5; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    redirect = 1'b1; target = 32'h100;
    cycle();
    redirect = 1'b0;
    checks++; if (s_req !== 1'b0 || s_hold !== 1'b0) begin failures++; $display("FAIL rd_redirect_cycle: got req=%b hold=%b expected 0/0", s_req, s_hold); end
    cycle();
    checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL rd_discard_full: got %b expected 0", s_req); end
    bad = s_valid ? 1 : 0;
    for (int i = 0; i < 3; i++) begin cycle(); if (s_valid) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL rd_drop_valid: got %0d valid cycles expected 0", bad); end
    p0 = n_pop; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin cycle(); if (n_pop > p0) got = 1'b1; end
    checks++; if (!got) begin failures++; $display("FAIL rd_timeout: got no output expected pc 100"); end
    checks++; if (last_pop_pc !== 32'h100) begin failures++; $display("FAIL rd_first_pc: got %h expected 100", last_pop_pc); end
  endtask

  task automatic test_redirect_rvalid();
    int p0, bad;
    logic got;
    do_reset(32'h0); lat = 2; id_ready = 1'b1;
    cycle(); cycle();
    redirect = 1'b1; target = 32'h200;
    cycle();
    redirect = 1'b0;
    checks++; if (s_hold !== 1'b0 || imem_rvalid !== 1'b1) begin failures++; $display("FAIL rr_hold: got hold=%b rvalid=%b expected 0/1", s_hold, imem_rvalid); end
    cycle();
    bad = s_valid ? 1 : 0;
    cycle(); if (s_valid) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rr_drop_valid: got %0d valid cycles expected 0", bad); end
    p0 = n_pop; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin cycle(); if (n_pop > p0) got = 1'b1; end
    checks++; if (!got || last_pop_pc !== 32'h200) begin failures++; $display("FAIL rr_first_pc: got %h expected 200", last_pop_pc); end
  endtask

  task automatic test_back_to_back();
    int r0, p0, holds, gaps;
    do_reset(32'h0); lat = 1; id_ready = 1'b1;
    r0 = n_req; p0 = n_pop; holds = 0; gaps = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (s_hold) holds++;
      if (i >= 2 && !s_valid) gaps++;
    end
    checks++; if (n_req - r0 != 16 || holds != 0) begin failures++; $display("FAIL b2b_issue: got %0d reqs %0d holds expected 16/0", n_req - r0, holds); end
    checks++; if (n_pop - p0 != 14 || gaps != 0) begin failures++; $display("FAIL b2b_pops: got %0d pops %0d gaps expected 14/0", n_pop - p0, gaps); end
    checks++; if (last_pop_pc !== 32'h34) begin failures++; $display("FAIL b2b_last_pc: got %h expected 34", last_pop_pc); end
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset(32'h0); lat = 1; id_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL mid_prefill: got %b expected 1", s_valid); end
    rst = 1'b0;
    cycle();
    checks++; if (s_valid !== 1'b0 || s_req !== 1'b0 || s_hold !== 1'b1 || s_instr !== NOP) begin
      failures++; $display("FAIL mid_reset: got v=%b req=%b hold=%b instr=%h expected 0/0/1/%h", s_valid, s_req, s_hold, s_instr, NOP);
    end
    rst = 1'b1; pc = 32'h40;
    inject = 1'b1; inject_data = 32'hDEADBEEF;
    cycle();
    inject = 1'b0;
    cycle();
    checks++; if (s_valid !== 1'b0 || s_instr !== NOP) begin failures++; $display("FAIL mid_unsolicited: got v=%b instr=%h expected 0/%h", s_valid, s_instr, NOP); end
    id_ready = 1'b1; p0 = n_pop;
    cycle(); cycle();
    checks++; if (n_pop - p0 != 2) begin failures++; $display("FAIL mid_recover: got %0d pops expected 2", n_pop - p0); end
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; id_ready = 1'b0; pc = 32'h0; target = 32'h0;
    pc_addr = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    lat = 1; cyc = 0; inject = 1'b0; inject_data = 32'h0;
    n_req = 0; n_pop = 0; last_pop_pc = 32'hFFFFFFFF;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_discard();
    test_redirect_rvalid();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
